// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the multi-channel RAM controller.
// Holds the per-channel status encoding, the default word type and the filler/latency limits.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    localparam word_t       BAD_WORD = 32'hBAD1BAD1;
    localparam int unsigned LAT_MAX  = 15;

    // Snapshot of one channel's request, used to detect a change while a grant is held.
    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
    } req_t;

endpackage

// File: rtl/ram_mc_if.sv
// Per-channel request/response bundle between requesters and ram_mc.
// The master modport is the requester side; the slave modport is the controller side.
interface ram_mc_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = 32
) ();
    import cpu_types_pkg::*;

    logic [NCH-1:0]     ramREN;
    logic [NCH-1:0]     ramWEN;
    word_t              ramaddr  [NCH];
    logic [WIDTH-1:0]   ramstore [NCH];
    logic [WIDTH/8-1:0] ramstrb  [NCH];
    logic [WIDTH-1:0]   ramload  [NCH];
    ramstate_t          ramstate [NCH];

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore, ramstrb,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore, ramstrb,
        output ramload, ramstate
    );

endinterface

// File: rtl/ram_mc_arb.sv
// Round-robin picker: grants the first requesting channel at or after the pointer when enabled.
// The pointer moves to the channel after the winner only when a new grant is issued.
module ram_mc_arb #(
    parameter  int unsigned NCH = 2,
    localparam int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [PW-1:0]  ptr
);
    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   c;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        c     = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            c = (32'(ptr_q) + i) % NCH;
            if (en && !found && req[c]) begin
                gnt[c] = 1'b1;
                found  = 1'b1;
                ptr_d  = PW'((c + 1) % NCH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ram_mc.sv
// ram_mc: NCH requesters share one memory port; one grant at a time, LAT wait cycles before ACCESS.
// Define RAM_MC_BYTE_STROBE_EN to honour ramstrb on writes; otherwise every write replaces the full word.
module ram_mc
    import cpu_types_pkg::*;
#(
    parameter int unsigned      NCH   = 2,
    parameter int unsigned      WIDTH = 32,
    parameter int unsigned      DEPTH = 16384,
    parameter int unsigned      LAT   = 0,
    parameter logic [WIDTH-1:0] BAD   = WIDTH'({((WIDTH + 31) / 32){BAD_WORD}})
) (
    input logic     CLK,
    input logic     RST,
    ram_mc_if.slave bus
);
    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned OFS   = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0]  LAT_C = 4'((LAT > LAT_MAX) ? LAT_MAX : LAT);

    logic [WIDTH-1:0] mem [DEPTH];

    req_t             cur  [NCH];
    word_t            widx [NCH];
    logic [NCH-1:0]   in_range, active, arb_gnt, gnt_vec;
    logic [PW-1:0]    unused_rr_ptr;
    logic             hold_q, hold_d, hold_ok, granted, access_ok, lat_reached, wr_en;
    logic [PW-1:0]    gch_q, gch_d;
    req_t             snap_q, snap_d;
    logic [3:0]       cnt_q, cnt_d, cnt_eff;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [NB-1:0]    wr_mask;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cur[i]      = '{ren: bus.ramREN[i], wen: bus.ramWEN[i], addr: bus.ramaddr[i]};
            widx[i]     = bus.ramaddr[i] >> OFS;
            in_range[i] = widx[i] < DEPTH;
            active[i]   = !RST && (bus.ramREN[i] ^ bus.ramWEN[i]) && in_range[i];
        end
    end

    // A held grant survives only while the owner presents the exact request it was granted with.
    always_comb begin
        hold_ok = hold_q && !RST && (cur[gch_q] == snap_q);
    end

    ram_mc_arb #(.NCH(NCH)) u_arb (
        .clk (CLK),
        .rst (RST),
        .en  (!hold_ok),
        .req (active),
        .gnt (arb_gnt),
        .ptr (unused_rr_ptr)
    );

    always_comb begin
        gnt_vec = '0;
        gch_d   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            gnt_vec[i] = hold_ok ? (gch_q == PW'(i)) : arb_gnt[i];
            if (gnt_vec[i]) begin
                gch_d = PW'(i);
            end
        end
        granted     = |gnt_vec;
        cnt_eff     = hold_ok ? cnt_q : '0;
        // cnt >= LAT written as cnt+1 > LAT so LAT=0 needs no special case.
        lat_reached = ({1'b0, cnt_eff} + 5'd1) > {1'b0, LAT_C};
        access_ok   = granted && lat_reached;
        hold_d      = granted;
        snap_d      = cur[gch_d];
        cnt_d       = !granted ? '0 : (lat_reached ? cnt_eff : cnt_eff + 4'd1);
        wr_en       = access_ok && cur[gch_d].wen;
        wr_idx      = widx[gch_d][AW-1:0];
        wr_data     = bus.ramstore[gch_d];
`ifdef RAM_MC_BYTE_STROBE_EN
        wr_mask     = bus.ramstrb[gch_d];
`else
        wr_mask     = '1;
`endif
    end

`ifndef RAM_MC_BYTE_STROBE_EN
    logic unused_strb;
    always_comb begin
        unused_strb = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            unused_strb = unused_strb ^ (^bus.ramstrb[i]);
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q <= 1'b0;
            gch_q  <= '0;
            snap_q <= '0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            gch_q  <= gch_d;
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (RST || (!bus.ramREN[i] && !bus.ramWEN[i])) begin
                bus.ramstate[i] = FREE;
            end else if ((bus.ramREN[i] && bus.ramWEN[i]) || !in_range[i]) begin
                bus.ramstate[i] = ERROR;
            end else if (gnt_vec[i] && access_ok) begin
                bus.ramstate[i] = ACCESS;
            end else begin
                bus.ramstate[i] = BUSY;
            end
            bus.ramload[i] = (gnt_vec[i] && access_ok && bus.ramREN[i]) ? mem[widx[i][AW-1:0]] : BAD;
        end
    end

endmodule

// File: tb/tb_ram_mc.sv
// Bench for ram_mc: two instances (LAT=0 and LAT=3) share stimulus and are checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_ram_mc;
    import cpu_types_pkg::*;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BADV  = 32'hBAD1BAD1;
`ifdef RAM_MC_BYTE_STROBE_EN
    localparam logic [31:0] EXP35 = 32'h1122CCDD;
`else
    localparam logic [31:0] EXP35 = 32'hAABBCCDD;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ren, wen;
    logic [31:0] addr  [2];
    logic [31:0] store [2];
    logic [3:0]  strb  [2];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_mc_if #(.NCH(2), .WIDTH(32)) bus0 ();
    ram_mc_if #(.NCH(2), .WIDTH(32)) bus1 ();

    always_comb begin
        bus0.ramREN = ren;
        bus0.ramWEN = wen;
        bus1.ramREN = ren;
        bus1.ramWEN = wen;
        for (int i = 0; i < 2; i++) begin
            bus0.ramaddr[i]  = addr[i];
            bus0.ramstore[i] = store[i];
            bus0.ramstrb[i]  = strb[i];
            bus1.ramaddr[i]  = addr[i];
            bus1.ramstore[i] = store[i];
            bus1.ramstrb[i]  = strb[i];
        end
    end

    ram_mc #(.NCH(2), .WIDTH(32), .DEPTH(DEPTH), .LAT(0)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    ram_mc #(.NCH(2), .WIDTH(32), .DEPTH(DEPTH), .LAT(3)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          own   [2];
    int          gcyc  [2];
    int          ptr   [2];
    logic        s_ren [2];
    logic        s_wen [2];
    logic [31:0] s_addr[2];
    logic [31:0] mm    [2][DEPTH];

    function automatic bit req_ok(input int c);
        return (ren[c] ^ wen[c]) && ((addr[c] >> 2) < DEPTH);
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int          lat, g, n, c;
            bit          holds;
            ramstate_t   es;
            logic [31:0] el, act_st, act_ld, widx;
            logic [3:0]  msk;
            lat = (d == 0) ? 0 : 3;
            g = -1;
            n = 0;
            holds = 1'b0;
            if (!rst) begin
                holds = own[d] >= 0 && ren[own[d]] == s_ren[d] && wen[own[d]] == s_wen[d]
                        && addr[own[d]] == s_addr[d];
                if (holds) begin
                    g = own[d];
                    n = gcyc[d];
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        c = (ptr[d] + k) % 2;
                        if (g < 0 && req_ok(c)) g = c;
                    end
                end
            end
            for (int ch = 0; ch < 2; ch++) begin
                widx = addr[ch] >> 2;
                if (rst || (!ren[ch] && !wen[ch])) es = FREE;
                else if ((ren[ch] && wen[ch]) || widx >= DEPTH) es = ERROR;
                else if (ch == g && n >= lat) es = ACCESS;
                else es = BUSY;
                el = (es == ACCESS && ren[ch]) ? mm[d][widx] : BADV;
                act_st = (d == 0) ? 32'(bus0.ramstate[ch]) : 32'(bus1.ramstate[ch]);
                act_ld = (d == 0) ? bus0.ramload[ch] : bus1.ramload[ch];
                chk($sformatf("model state lat%0d ch%0d", lat, ch), act_st, 32'(es));
                chk($sformatf("model load lat%0d ch%0d", lat, ch), act_ld, el);
            end
            if (rst) begin
                own[d]  = -1;
                gcyc[d] = 0;
                ptr[d]  = 0;
            end else begin
                if (g >= 0 && n >= lat && wen[g]) begin
`ifdef RAM_MC_BYTE_STROBE_EN
                    msk = strb[g];
`else
                    msk = 4'hF;
`endif
                    widx = addr[g] >> 2;
                    for (int b = 0; b < 4; b++)
                        if (msk[b]) mm[d][widx][8*b +: 8] = store[g][8*b +: 8];
                end
                own[d] = g;
                if (g >= 0) begin
                    s_ren[d]  = ren[g];
                    s_wen[d]  = wen[g];
                    s_addr[d] = addr[g];
                    gcyc[d]   = n + 1;
                    if (!holds) ptr[d] = (g + 1) % 2;
                end else begin
                    gcyc[d] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] s, input logic [3:0] st);
        ren[c]   = r;
        wen[c]   = w;
        addr[c]  = a;
        store[c] = s;
        strb[c]  = st;
    endtask

    task automatic idle_all();
        set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            own[d] = -1;
            gcyc[d] = 0;
            ptr[d] = 0;
        end
        rst = 1'b1;
        idle_all();
        set_ch(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        #1;
        chk("reset state", 32'(bus0.ramstate[0]), 32'(FREE));
        chk("reset load", bus1.ramload[0], BADV);
        tick();
        rst = 1'b0;
        idle_all();

        // fill every word so later reads compare against known data
        for (int w = 0; w < DEPTH; w++) begin
            tick();
            set_ch(0, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF);
            repeat (3) tick();
        end
        tick();
        idle_all();

        // write then read 0x100
        tick();
        set_ch(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        #1;
        chk("lat0 write access", 32'(bus0.ramstate[0]), 32'(ACCESS));
        repeat (3) tick();
        tick();
        set_ch(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        #1;
        chk("lat0 read access", 32'(bus0.ramstate[0]), 32'(ACCESS));
        chk("lat0 read data", bus0.ramload[0], 32'hDEADBEEF);
        chk("lat3 read busy", 32'(bus1.ramstate[0]), 32'(BUSY));
        chk("lat3 read bad", bus1.ramload[0], BADV);
        repeat (3) tick();
        #1;
        chk("lat3 read data", bus1.ramload[0], 32'hDEADBEEF);
        tick();
        idle_all();

        // ch1 held read under LAT=3
        tick();
        set_ch(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            #1;
            chk($sformatf("lat3 wait cyc%0d", k), 32'(bus1.ramstate[1]),
                32'((k < 3) ? BUSY : ACCESS));
            if (k < 3) chk($sformatf("lat3 wait load cyc%0d", k), bus1.ramload[1], BADV);
        end
        tick();
        idle_all();

        // tie from pointer 0, hand-over on drop
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ch(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        set_ch(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        #1;
        chk("tie ch0 wins", 32'(bus0.ramstate[0]), 32'(ACCESS));
        chk("tie ch1 waits", 32'(bus0.ramstate[1]), 32'(BUSY));
        tick();
        set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("handover ch1", 32'(bus0.ramstate[1]), 32'(ACCESS));
        tick();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ch(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        set_ch(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        idle_all();
        tick();
        set_ch(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        set_ch(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        #1;
        chk("second tie ch1 wins", 32'(bus0.ramstate[1]), 32'(ACCESS));
        chk("second tie ch0 waits", 32'(bus0.ramstate[0]), 32'(BUSY));
        tick();
        idle_all();

        // partial-strobe write
        tick();
        set_ch(0, 1'b0, 1'b1, 32'h200, 32'h11223344, 4'hF);
        repeat (3) tick();
        tick();
        set_ch(0, 1'b0, 1'b1, 32'h200, 32'hAABBCCDD, 4'h3);
        repeat (3) tick();
        tick();
        set_ch(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        repeat (3) tick();
        #1;
        chk("strobe lat0", bus0.ramload[0], EXP35);
        chk("strobe lat3", bus1.ramload[0], EXP35);

        // error requests
        tick();
        set_ch(0, 1'b1, 1'b1, 32'h100, 32'h0, 4'hF);
        #1;
        chk("both error", 32'(bus0.ramstate[0]), 32'(ERROR));
        chk("both bad", bus0.ramload[0], BADV);
        repeat (3) tick();
        tick();
        set_ch(0, 1'b0, 1'b1, 32'(DEPTH * 4), 32'h0, 4'hF);
        #1;
        chk("range write error", 32'(bus1.ramstate[0]), 32'(ERROR));
        repeat (3) tick();
        tick();
        set_ch(0, 1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, 4'h0);
        #1;
        chk("range read error", 32'(bus0.ramstate[0]), 32'(ERROR));
        chk("range read bad", bus0.ramload[0], BADV);
        tick();
        set_ch(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        repeat (3) tick();
        #1;
        chk("unchanged lat0", bus0.ramload[0], 32'hDEADBEEF);
        chk("unchanged lat3", bus1.ramload[0], 32'hDEADBEEF);

        // reset during the LAT wait
        tick();
        idle_all();
        tick();
        set_ch(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        #1;
        chk("pre-reset busy", 32'(bus1.ramstate[0]), 32'(BUSY));
        tick();
        rst = 1'b1;
        #1;
        chk("mid reset free", 32'(bus1.ramstate[0]), 32'(FREE));
        chk("mid reset bad", bus1.ramload[0], BADV);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            #1;
            chk($sformatf("restart cyc%0d", k), 32'(bus1.ramstate[0]),
                32'((k < 3) ? BUSY : ACCESS));
        end
        chk("restart data", bus1.ramload[0], 32'hDEADBEEF);
        tick();
        idle_all();

        // randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 9) < 2) begin
                    int          kind;
                    logic [31:0] a;
                    kind = int'($urandom_range(0, 9));
                    a = ($urandom_range(0, 9) == 0) ? 32'(DEPTH * 4) + $urandom_range(0, 255)
                                                    : $urandom_range(0, DEPTH * 4 - 1);
                    set_ch(c, kind >= 2 && (kind <= 5 || kind == 9), kind >= 6, a,
                           $urandom, 4'($urandom_range(0, 15)));
                end
            end
        end
        tick();
        rst = 1'b0;
        idle_all();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
